matrix_row_fetch: RTL

Fetches the pixel data for the next display row pair from the framebuffer into a ping-pong line buffer. It then serves per-column RGB bits, sliced by the current brightness bit-plane, to the panel shift-out path. It sits between the framebuffer read port and `matrix_scan`: it consumes the scanner's column, row and brightness signals and produces the six colour data lines sampled on the panel pixel clock.

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/line_buffer.sv | 31 +++
 rtl/matrix_row_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, RGB666 field layout and fetch FSM encoding for the
// matrix panel row-fetch path.
package matrix_pkg;

   localparam int MATRIX_COLS      = 64;
   localparam int MATRIX_ROWS_HALF = 16;
   localparam int PIXEL_WIDTH      = 18;
   localparam int CHANNEL_WIDTH    = 6;
   localparam int R_LSB            = 12;
   localparam int G_LSB            = 6;
   localparam int B_LSB            = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_DRAIN
   } fetch_state_t;

   // Slice one RGB666 word by a bit-plane mask; a non-one-hot mask ORs its planes.
   function automatic logic [2:0] plane_bits(input logic [PIXEL_WIDTH-1:0]   word,
                                             input logic [CHANNEL_WIDTH-1:0] mask);
      logic [CHANNEL_WIDTH-1:0] r;
      logic [CHANNEL_WIDTH-1:0] g;
      logic [CHANNEL_WIDTH-1:0] b;
      r = word[R_LSB +: CHANNEL_WIDTH];
      g = word[G_LSB +: CHANNEL_WIDTH];
      b = word[B_LSB +: CHANNEL_WIDTH];
      return {|(r & mask), |(g & mask), |(b & mask)};
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Ping-pong line buffer: two banks of 64 top + 64 bottom pixel words,
// one synchronous write port and two asynchronous read ports at one column.
module line_buffer
   import matrix_pkg::*;
#(
   parameter int WIDTH = PIXEL_WIDTH
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [6:0]       wr_index,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_bank,
   input  logic [5:0]       rd_col,
   output logic [WIDTH-1:0] rd_top,
   output logic [WIDTH-1:0] rd_bottom
);

   // Index layout: {bank, half, column}
   logic [WIDTH-1:0] mem [0:4*MATRIX_COLS-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_index}] <= wr_data;
      end
   end

   assign rd_top    = mem[{rd_bank, 1'b0, rd_col}];
   assign rd_bottom = mem[{rd_bank, 1'b1, rd_col}];

endmodule

// File: rtl/matrix_row_fetch.sv
// Prefetches the next row pair from the framebuffer into the back bank of a
// ping-pong line buffer and serves bit-plane sliced RGB bits from the front bank.
module matrix_row_fetch #(
   parameter int FB_ADDR_WIDTH = 11,
   parameter int PIXEL_WIDTH   = 18
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     pixel_load_en,
   input  logic [5:0]               column_address,
   input  logic [3:0]               row_address,
   input  logic [5:0]               brightness_mask,
   output logic                     fb_rd_req,
   output logic [FB_ADDR_WIDTH-1:0] fb_rd_addr,
   input  logic                     fb_rd_ack,
   input  logic [PIXEL_WIDTH-1:0]   fb_rd_data,
   output logic [2:0]               rgb_top,
   output logic [2:0]               rgb_bottom,
   output logic                     fetch_busy,
   output logic                     underrun
);

   import matrix_pkg::*;

   fetch_state_t state;
   fetch_state_t state_next;

   logic [3:0]             row_prev;
   logic                   start_pending;
   logic                   row_change;
   logic                   fetch_start;
   logic                   bank_sel;
   logic                   front_valid;
   logic                   back_valid;
   logic [6:0]             fetch_index;
   logic [3:0]             fetch_row;
   logic                   wr_pending;
   logic [6:0]             wr_index;
   logic                   ack_taken;
   logic                   last_ack;
   logic                   wr_en;
   logic [PIXEL_WIDTH-1:0] rd_top;
   logic [PIXEL_WIDTH-1:0] rd_bottom;

   assign row_change  = (row_address != row_prev);
   assign fetch_start = start_pending | row_change;
   // A restart wins over an ack in the same cycle and squashes any in-flight write.
   assign ack_taken   = (state == FETCH_REQ) && fb_rd_ack && !fetch_start;
   assign last_ack    = ack_taken && (fetch_index == 7'd127);
   assign wr_en       = wr_pending && !fetch_start;
   assign fb_rd_addr  = FB_ADDR_WIDTH'({fetch_index[6], fetch_row, fetch_index[5:0]});

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state <= FETCH_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (fetch_start) begin
         state_next = FETCH_REQ;
      end else begin
         unique case (state)
            FETCH_IDLE:  state_next = FETCH_IDLE;
            FETCH_REQ:   if (last_ack) state_next = FETCH_DRAIN;
            FETCH_DRAIN: state_next = FETCH_IDLE;
            default:     state_next = FETCH_IDLE;
         endcase
      end
   end

   always_comb begin
      fb_rd_req  = (state == FETCH_REQ);
      fetch_busy = (state != FETCH_IDLE);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         row_prev      <= '0;
         start_pending <= 1'b1;
         bank_sel      <= 1'b0;
         front_valid   <= 1'b0;
         back_valid    <= 1'b0;
         underrun      <= 1'b0;
         fetch_index   <= '0;
         fetch_row     <= '0;
         wr_pending    <= 1'b0;
         wr_index      <= '0;
      end else begin
         row_prev      <= row_address;
         start_pending <= 1'b0;
         if (fetch_start) begin
            fetch_index <= '0;
            fetch_row   <= row_address + 4'd1;
            wr_pending  <= 1'b0;
            back_valid  <= 1'b0;
            if (row_change) begin
               if (back_valid) begin
                  bank_sel    <= ~bank_sel;
                  front_valid <= 1'b1;
               end else begin
                  front_valid <= 1'b0;
                  underrun    <= 1'b1;
               end
            end
         end else begin
            wr_pending <= ack_taken;
            if (ack_taken) begin
               wr_index    <= fetch_index;
               fetch_index <= fetch_index + 7'd1;
            end
            if (state == FETCH_DRAIN) begin
               back_valid <= 1'b1;
            end
         end
      end
   end

   line_buffer #(
      .WIDTH(PIXEL_WIDTH)
   ) u_line_buffer (
      .clk       (clk_in),
      .wr_en     (wr_en),
      .wr_bank   (~bank_sel),
      .wr_index  (wr_index),
      .wr_data   (fb_rd_data),
      .rd_bank   (bank_sel),
      .rd_col    (column_address),
      .rd_top    (rd_top),
      .rd_bottom (rd_bottom)
   );

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         rgb_top    <= '0;
         rgb_bottom <= '0;
      end else if (pixel_load_en) begin
         rgb_top    <= front_valid ? plane_bits(rd_top, brightness_mask)    : '0;
         rgb_bottom <= front_valid ? plane_bits(rd_bottom, brightness_mask) : '0;
      end
   end

endmodule
